// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the memory-mapped UART
//                (receive FSM states, register addresses, status bit map).
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Receive engine states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  // UART register addresses as seen by the LSU
  localparam logic [9:0] TX_DATA  = 10'h3FC;
  localparam logic [9:0] RX_DATA  = 10'h3FD;
  localparam logic [9:0] BAUD_CFG = 10'h3FE;
  localparam logic [9:0] STATUS   = 10'h3FF;

  // Bit positions inside the status word
  localparam int unsigned RX_VALID  = 0;
  localparam int unsigned FRAME_ERR = 1;
  localparam int unsigned OVERRUN   = 2;
  localparam int unsigned TX_BUSY   = 3;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync
//  Description : Multi-flop synchroniser for an asynchronous, idle-high
//                serial line. Flops reset to 1 so the line reads idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // A depth below two gives no metastability protection at all
  generate
    if (SYNC_STAGES >= 2) begin : g_chain
      // Shift the raw input into the chain one stage per clock
      always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
      end
    end else begin : g_single
      // Degenerate single-flop fallback
      always_comb begin
        sync_d = async_in;
      end
    end
  endgenerate

  // Synchroniser flops, reset to the idle (high) line level
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

endmodule : uart_sync
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_core
//  Description : 8N1 serial receive engine with a one-byte holding register,
//                sticky frame/overrun status and LSU pop-on-read.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             uart_rx,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             rd_ack,
  input  logic             clr_err,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             overrun,
  output logic             rx_busy
);

  logic             rxs;

  rx_state_e        state_q,     state_d;
  logic [DIV_W-1:0] cnt_q,       cnt_d;
  logic [DIV_W-1:0] div_q,       div_d;
  logic [2:0]       bit_idx_q,   bit_idx_d;
  logic [7:0]       shreg_q,     shreg_d;
  logic [7:0]       rx_data_q,   rx_data_d;
  logic             rx_valid_q,  rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q,   overrun_d;

  logic             done;
  logic             err_set;
  logic             ovr_set;

  uart_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (uart_rx),
    .sync_out (rxs)
  );

  // Frame sequencing plus holding-register and sticky-status next state
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    done        = 1'b0;
    err_set     = 1'b0;
    ovr_set     = 1'b0;

    case (state_q)
      IDLE: begin
        // Divisor is captured here so a mid-frame change waits for the next frame
        if (!rxs) begin
          div_d   = baud_div;
          cnt_d   = (baud_div >> 1) - {{(DIV_W-1){1'b0}}, 1'b1};
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (rxs) begin
            state_d = IDLE;
          end else begin
            cnt_d     = div_q - {{(DIV_W-1){1'b0}}, 1'b1};
            bit_idx_d = 3'd0;
            state_d   = DATA;
          end
        end else begin
          cnt_d = cnt_q - {{(DIV_W-1){1'b0}}, 1'b1};
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shreg_d = {rxs, shreg_q[7:1]};
          cnt_d   = div_q - {{(DIV_W-1){1'b0}}, 1'b1};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - {{(DIV_W-1){1'b0}}, 1'b1};
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          done    = 1'b1;
          err_set = ~rxs;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - {{(DIV_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A same-cycle read frees the holding register for the incoming byte
    if (done) begin
      if (!rx_valid_q || rd_ack) begin
        rx_data_d  = shreg_q;
        rx_valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (rd_ack) begin
      rx_valid_d = 1'b0;
    end

    // Clear first so that a coincident new error wins
    if (clr_err) begin
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end
    if (err_set) begin
      frame_err_d = 1'b1;
    end
    if (ovr_set) begin
      overrun_d = 1'b1;
    end
  end

  // State and register update; reset discards any partial frame
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      bit_idx_q   <= 3'd0;
      shreg_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign rx_busy   = (state_q != IDLE);

endmodule : uart_rx_core
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_core
//  Description : Self-checking bench for uart_rx_core. A frame-level model
//                predicts holding register and status every cycle; directed
//                literal checks pin the model at key points.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;

  localparam int DIV_W = 16;
  localparam int SYNC  = 2;

  logic             clk      = 1'b0;
  logic             reset    = 1'b0;
  logic             uart_rx  = 1'b1;
  logic [DIV_W-1:0] baud_div = 16'd8;
  logic             rd_ack   = 1'b0;
  logic             clr_err  = 1'b0;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             frame_err;
  logic             overrun;
  logic             rx_busy;

  uart_rx_core #(
    .DIV_W       (DIV_W),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .uart_rx   (uart_rx),
    .baud_div  (baud_div),
    .rd_ack    (rd_ack),
    .clr_err   (clr_err),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- frame-level model ----------------
  // Each sent frame becomes one expected completion: the stop bit is sampled
  // SYNC + 1 + div/2 + 9*div posedges after the start edge is driven.
  typedef struct {
    int         comp;
    logic [7:0] data;
    bit         stop;
  } frame_t;

  frame_t     pend[$];
  logic [7:0] m_data  = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_fe    = 1'b0;
  logic       m_ov    = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      m_data  <= 8'h00;
      m_valid <= 1'b0;
      m_fe    <= 1'b0;
      m_ov    <= 1'b0;
      pend.delete();
    end else if (pend.size() > 0 && pend[0].comp == cyc + 1) begin
      if (!m_valid || rd_ack) begin
        m_data  <= pend[0].data;
        m_valid <= 1'b1;
      end
      m_fe <= !pend[0].stop ? 1'b1 : (clr_err ? 1'b0 : m_fe);
      m_ov <= (m_valid && !rd_ack) ? 1'b1 : (clr_err ? 1'b0 : m_ov);
      pend.pop_front();
    end else begin
      if (rd_ack) m_valid <= 1'b0;
      if (clr_err) begin
        m_fe <= 1'b0;
        m_ov <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_rx_data", {24'd0, rx_data}, {24'd0, m_data});
      chk("model_rx_valid", {31'd0, rx_valid}, {31'd0, m_valid});
      chk("model_frame_err", {31'd0, frame_err}, {31'd0, m_fe});
      chk("model_overrun", {31'd0, overrun}, {31'd0, m_ov});
    end
  end

  // Cycle on which rx_valid was last seen rising
  logic prev_v = 1'b0;
  int   rise_cyc = 0;
  always @(negedge clk) begin
    if (rx_valid === 1'b1 && prev_v !== 1'b1) rise_cyc <= cyc;
    prev_v <= rx_valid;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ack();
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
  endtask

  int last_edge = 0;

  // Drive one 8N1 frame. ack_done strobes rd_ack on the completion cycle;
  // rst_bit >= 0 pulses reset for two clocks at that frame bit position.
  task automatic send(input logic [7:0] b, input bit stop, input int div,
                      input bit expect_done, input bit ack_done, input int rst_bit);
    logic [9:0] fr;
    int comp;
    frame_t f;
    fr = {stop, b, 1'b0};
    @(posedge clk);
    #1;
    last_edge = cyc;
    comp = cyc + SYNC + 1 + div / 2 + 9 * div;
    if (expect_done) begin
      f.comp = comp;
      f.data = b;
      f.stop = stop;
      pend.push_back(f);
    end
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      for (int j = 0; j < div; j++) begin
        reset  = !(i == rst_bit && j < 2);
        rd_ack = ack_done && (cyc == comp - 1);
        @(posedge clk);
        #1;
      end
    end
    rd_ack  = 1'b0;
    reset   = 1'b1;
    uart_rx = 1'b1;
    tick(div);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b0;
    tick(4);
    chk("reset_rx_data", {24'd0, rx_data}, 32'h00);
    chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset_overrun", {31'd0, overrun}, 32'd0);
    chk("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
    cmp_en = 1'b1;
    reset  = 1'b1;
    tick(4);

    // Plain byte at 8 clocks per bit
    send(8'hA5, 1'b1, 8, 1'b1, 1'b0, -1);
    tick(2);
    chk("a5_data", {24'd0, rx_data}, 32'hA5);
    chk("a5_valid", {31'd0, rx_valid}, 32'd1);
    chk("a5_frame_err", {31'd0, frame_err}, 32'd0);
    chk("a5_latency_window", {31'd0, (rise_cyc - last_edge >= 77) && (rise_cyc - last_edge <= 83)}, 32'd1);
    pulse_ack();
    chk("a5_ack_pops", {31'd0, rx_valid}, 32'd0);

    // Two-clock glitch: engine enters START then abandons the frame
    @(posedge clk);
    #1;
    uart_rx = 1'b0;
    tick(2);
    uart_rx = 1'b1;
    tick(1);
    chk("glitch_busy", {31'd0, rx_busy}, 32'd1);
    tick(20);
    chk("glitch_idle", {31'd0, rx_busy}, 32'd0);
    chk("glitch_valid", {31'd0, rx_valid}, 32'd0);
    chk("glitch_flags", {30'd0, frame_err, overrun}, 32'd0);
    send(8'h3C, 1'b1, 8, 1'b1, 1'b0, -1);
    tick(2);
    chk("3c_data", {24'd0, rx_data}, 32'h3C);
    chk("3c_valid", {31'd0, rx_valid}, 32'd1);
    pulse_ack();

    // Stop bit driven low: byte still delivered, frame_err sticky until cleared
    send(8'h5A, 1'b0, 8, 1'b1, 1'b0, -1);
    tick(2);
    chk("ferr_data", {24'd0, rx_data}, 32'h5A);
    chk("ferr_valid", {31'd0, rx_valid}, 32'd1);
    chk("ferr_flag", {31'd0, frame_err}, 32'd1);
    pulse_clr();
    chk("ferr_cleared", {31'd0, frame_err}, 32'd0);
    pulse_ack();

    // Overrun: second byte dropped while the first is unread
    send(8'h11, 1'b1, 8, 1'b1, 1'b0, -1);
    send(8'h22, 1'b1, 8, 1'b1, 1'b0, -1);
    tick(2);
    chk("ovr_data_kept", {24'd0, rx_data}, 32'h11);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    chk("ovr_valid", {31'd0, rx_valid}, 32'd1);
    pulse_ack();
    pulse_clr();
    chk("ovr_cleared", {31'd0, overrun}, 32'd0);

    // Read coinciding with completion makes room for the new byte
    send(8'h11, 1'b1, 8, 1'b1, 1'b0, -1);
    send(8'h22, 1'b1, 8, 1'b1, 1'b1, -1);
    tick(2);
    chk("ackcomp_data", {24'd0, rx_data}, 32'h22);
    chk("ackcomp_valid", {31'd0, rx_valid}, 32'd1);
    chk("ackcomp_no_ovr", {31'd0, overrun}, 32'd0);

    // Reset during data bit 3 of 0xFF (frame position 4)
    send(8'hFF, 1'b1, 8, 1'b0, 1'b0, 4);
    chk("midrst_outputs", {24'd0, rx_data}, 32'h00);
    chk("midrst_status", {28'd0, rx_valid, frame_err, overrun, rx_busy}, 32'd0);
    send(8'h81, 1'b1, 8, 1'b1, 1'b0, -1);
    tick(2);
    chk("81_data", {24'd0, rx_data}, 32'h81);
    chk("81_valid", {31'd0, rx_valid}, 32'd1);
    pulse_ack();

    // Divisor change mid-frame applies only to the following frame
    baud_div = 16'd8;
    fork
      send(8'h96, 1'b1, 8, 1'b1, 1'b0, -1);
      begin
        tick(40);
        baud_div = 16'd16;
      end
    join
    tick(2);
    chk("divchg_old_rate", {24'd0, rx_data}, 32'h96);
    pulse_ack();
    send(8'hC3, 1'b1, 16, 1'b1, 1'b0, -1);
    tick(2);
    chk("divchg_new_rate", {24'd0, rx_data}, 32'hC3);
    chk("divchg_valid", {31'd0, rx_valid}, 32'd1);
    chk("divchg_flags", {30'd0, frame_err, overrun}, 32'd0);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_uart_rx_core
`default_nettype wire
